psum_exchange_rx: RTL and testbench

- Consuming end of the inter-core partial-sum exchange. Pops the partner core's row sum from the async FIFO read port and pairs it with this core's locally produced row sum.
- Emits the combined normalisation denominator for the core's divider stage.
- Lives inside each core on the core's own clock, on the read side of the partner's FIFO.
- mode=1 is single-core operation: the FIFO is ignored and the local sum passes through.

---
 rtl/psum_xchg_pkg.sv | 23 ++
 rtl/psum_local_queue.sv | 56 +++++
 rtl/psum_exchange_rx.sv | 108 ++++++++++
 tb/tb_psum_exchange_rx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_xchg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : psum_xchg_pkg
// Purpose : Shared constants and FSM encoding for the partial-sum exchange
//           receive path.
// Revision: 1.0 - initial release
// ============================================================================
package psum_xchg_pkg;

  localparam int BW_PSUM    = 20;
  localparam int SUM_W      = BW_PSUM + 4;
  localparam int LQ_DEPTH   = 4;
  localparam int PAIR_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CAP  = 2'd2,
    ST_OUT  = 2'd3
  } xchg_state_t;

endpackage
`default_nettype wire

// File: rtl/psum_local_queue.sv
`default_nettype none
// ============================================================================
// Module  : psum_local_queue
// Purpose : Small synchronous FIFO holding locally produced row sums until
//           the partner's matching sum is available.
// Revision: 1.0 - initial release
// ============================================================================
module psum_local_queue
  import psum_xchg_pkg::*;
#(
  parameter int SUM_W    = psum_xchg_pkg::SUM_W,
  parameter int LQ_DEPTH = psum_xchg_pkg::LQ_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [SUM_W-1:0] push_data,
  input  logic             pop,
  output logic [SUM_W-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [SUM_W-1:0] mem [LQ_DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; a push while full is silently dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/psum_exchange_rx.sv
`default_nettype none
// ============================================================================
// Module  : psum_exchange_rx
// Purpose : Pairs this core's row sum with the partner core's row sum popped
//           from the async FIFO and emits the combined denominator. In
//           single-core mode the local sum passes straight through.
// Revision: 1.0 - initial release
// ============================================================================
module psum_exchange_rx
  import psum_xchg_pkg::*;
#(
  parameter int SUM_W    = psum_xchg_pkg::SUM_W,
  parameter int LQ_DEPTH = psum_xchg_pkg::LQ_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [SUM_W-1:0]      local_sum,
  input  logic                  local_vld,
  output logic                  local_rdy,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [SUM_W-1:0]      fifo_rd_data,
  output logic [SUM_W:0]        total_sum,
  output logic                  total_vld,
  input  logic                  total_rdy,
  output logic [PAIR_CNT_W-1:0] pair_cnt,
  output logic                  busy
);

  xchg_state_t      state;
  xchg_state_t      state_nxt;
  logic [SUM_W-1:0] q_head;
  logic             q_full;
  logic             q_empty;
  logic             q_pop;
  logic             load_sum;
  logic [SUM_W:0]   sum_nxt;

  psum_local_queue #(
    .SUM_W    (SUM_W),
    .LQ_DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk       (clk),
    .reset     (reset),
    .push      (local_vld),
    .push_data (local_sum),
    .pop       (q_pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign local_rdy = ~q_full;
  assign fifo_rd   = (state == ST_RD);
  assign total_vld = (state == ST_OUT);
  assign busy      = (state != ST_IDLE) || !q_empty;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state, queue pop and total load; mode only matters in IDLE.
  always_comb begin
    state_nxt = state;
    q_pop     = 1'b0;
    load_sum  = 1'b0;
    sum_nxt   = {1'b0, q_head};
    case (state)
      ST_IDLE: begin
        if (!q_empty) begin
          if (mode) begin
            // Bypass: remote contribution is zero.
            q_pop     = 1'b1;
            load_sum  = 1'b1;
            state_nxt = ST_OUT;
          end else if (!fifo_empty) begin
            state_nxt = ST_RD;
          end
        end
      end
      ST_RD:  state_nxt = ST_CAP;
      ST_CAP: begin
        q_pop     = 1'b1;
        load_sum  = 1'b1;
        sum_nxt   = {1'b0, q_head} + {1'b0, fifo_rd_data};
        state_nxt = ST_OUT;
      end
      ST_OUT: if (total_rdy) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output sum register and completed-pair counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_sum <= '0;
      pair_cnt  <= '0;
    end else begin
      if (load_sum) total_sum <= sum_nxt;
      if (state == ST_OUT && total_rdy) pair_cnt <= pair_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psum_exchange_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_psum_exchange_rx
// Purpose : Directed self-checking bench for psum_exchange_rx, with a small
//           behavioural model of the partner's FIFO read port.
// Revision: 1.0 - initial release
// ============================================================================
module tb_psum_exchange_rx;

  localparam int SUM_W = 24;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             mode = 1'b0;
  logic [SUM_W-1:0] local_sum = '0;
  logic             local_vld = 1'b0;
  logic             local_rdy;
  logic             fifo_empty;
  logic             fifo_rd;
  logic [SUM_W-1:0] fifo_rd_data;
  logic [SUM_W:0]   total_sum;
  logic             total_vld;
  logic             total_rdy = 1'b0;
  logic [7:0]       pair_cnt;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;
  int exp_pairs = 0;

  // Partner FIFO model: written by the stimulus, popped by fifo_rd.
  logic [SUM_W-1:0] fmem [16];
  int fwr = 0;
  int frd = 0;
  int rd_count = 0;

  assign fifo_empty = (fwr == frd);

  psum_exchange_rx dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .local_sum    (local_sum),
    .local_vld    (local_vld),
    .local_rdy    (local_rdy),
    .fifo_empty   (fifo_empty),
    .fifo_rd      (fifo_rd),
    .fifo_rd_data (fifo_rd_data),
    .total_sum    (total_sum),
    .total_vld    (total_vld),
    .total_rdy    (total_rdy),
    .pair_cnt     (pair_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // FIFO read port: data is valid the cycle after the pop strobe.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      frd          <= 0;
      fifo_rd_data <= '0;
    end else if (fifo_rd) begin
      fifo_rd_data <= fmem[frd % 16];
      frd          <= frd + 1;
    end
  end

  // Pop-strobe counter.
  always @(posedge clk) begin
    if (fifo_rd && !reset) rd_count <= rd_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fifo_put(input logic [SUM_W-1:0] v);
    fmem[fwr % 16] = v;
    fwr = fwr + 1;
  endtask

  // Called at a negedge; the push happens on the following posedge.
  task automatic push_local(input logic [SUM_W-1:0] v);
    local_sum = v;
    local_vld = 1'b1;
    @(negedge clk);
    local_vld = 1'b0;
  endtask

  // Counts edges after the push edge until total_vld is seen.
  task automatic wait_vld(input string tag, output int edges);
    edges = 0;
    while (total_vld !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    if (total_vld !== 1'b1) check({tag, "_timeout"}, {31'd0, total_vld}, 32'd1);
  endtask

  task automatic accept();
    total_rdy = 1'b1;
    @(negedge clk);
    total_rdy = 1'b0;
    exp_pairs++;
  endtask

  initial begin
    int lat;
    int rc0;
    logic saw_vld;
    logic [SUM_W-1:0] vals [4];

    // Reset state, sampled while reset is held.
    #2;
    check("rst_local_rdy", {31'd0, local_rdy}, 32'd1);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_total_vld", {31'd0, total_vld}, 32'd0);
    check("rst_fifo_rd",   {31'd0, fifo_rd},   32'd0);
    check("rst_pair_cnt",  {24'd0, pair_cnt},  32'd0);
    check("rst_total_sum", {7'd0, total_sum},  32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Dual, basic pairing.
    fifo_put(24'h000050);
    rc0 = rd_count;
    push_local(24'h000100);
    wait_vld("basic", lat);
    check("basic_latency", lat, 3);
    check("basic_sum", {7'd0, total_sum}, 32'h150);
    check("basic_rd_pulses", rd_count - rc0, 1);
    check("basic_cnt_before", {24'd0, pair_cnt}, 32'd0);
    accept();
    check("basic_cnt_after", {24'd0, pair_cnt}, exp_pairs);
    check("basic_vld_drop", {31'd0, total_vld}, 32'd0);

    // Widest operands: result needs the extra bit.
    fifo_put(24'hFFFFFF);
    push_local(24'hFFFFFF);
    wait_vld("ovf", lat);
    check("ovf_sum", {7'd0, total_sum}, 32'h1FFFFFE);
    accept();

    // Starvation: local sum waits while the partner FIFO stays empty.
    rc0 = rd_count;
    push_local(24'h10);
    saw_vld = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw_vld = saw_vld | total_vld;
    end
    check("starve_no_rd", rd_count - rc0, 0);
    check("starve_busy", {31'd0, busy}, 32'd1);
    check("starve_no_vld", {31'd0, saw_vld}, 32'd0);
    fifo_put(24'h20);
    wait_vld("starve", lat);
    check("starve_sum", {7'd0, total_sum}, 32'h30);
    accept();
    check("starve_cnt", {24'd0, pair_cnt}, exp_pairs);

    // Local queue fills; fifth push is dropped.
    for (int i = 1; i <= 5; i++) begin
      local_sum = SUM_W'(i);
      local_vld = 1'b1;
      @(negedge clk);
      if (i == 3) check("lq_rdy_after3", {31'd0, local_rdy}, 32'd1);
      if (i == 4) check("lq_rdy_after4", {31'd0, local_rdy}, 32'd0);
    end
    local_vld = 1'b0;
    check("lq_busy_full", {31'd0, busy}, 32'd1);
    fifo_put(24'h10);
    fifo_put(24'h20);
    fifo_put(24'h30);
    fifo_put(24'h40);
    vals[0] = 24'h11; vals[1] = 24'h22; vals[2] = 24'h33; vals[3] = 24'h44;
    total_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_vld("lq", lat);
      check($sformatf("lq_sum%0d", k), {7'd0, total_sum}, {8'd0, vals[k]});
      @(negedge clk);
    end
    total_rdy = 1'b0;
    exp_pairs += 4;
    check("lq_cnt", {24'd0, pair_cnt}, exp_pairs);
    repeat (8) @(negedge clk);
    check("lq_drained_busy", {31'd0, busy}, 32'd0);
    check("lq_no_fifth", {31'd0, total_vld}, 32'd0);
    check("lq_rdy_again", {31'd0, local_rdy}, 32'd1);

    // Bypass: FIFO is non-empty but must not be touched.
    mode = 1'b1;
    fifo_put(24'h000999);
    rc0 = rd_count;
    push_local(24'h000ABC);
    wait_vld("byp", lat);
    check("byp_latency", lat, 1);
    check("byp_sum", {7'd0, total_sum}, 32'h0ABC);
    accept();
    check("byp_no_rd", rd_count - rc0, 0);
    check("byp_cnt", {24'd0, pair_cnt}, exp_pairs);
    mode = 1'b0;
    @(negedge clk);

    // Reset while in CAP (FIFO still holds 0x999 from above).
    push_local(24'h000005);
    @(negedge clk);
    check("mid_in_rd", {31'd0, fifo_rd}, 32'd1);
    @(negedge clk);
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_fifo_rd", {31'd0, fifo_rd},   32'd0);
    check("mid_vld",     {31'd0, total_vld}, 32'd0);
    check("mid_cnt",     {24'd0, pair_cnt},  32'd0);
    check("mid_busy",    {31'd0, busy},      32'd0);
    check("mid_rdy",     {31'd0, local_rdy}, 32'd1);
    check("mid_sum",     {7'd0, total_sum},  32'd0);
    fwr = 0;
    exp_pairs = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    // Normal operation resumes after reset.
    fifo_put(24'h7);
    push_local(24'h8);
    wait_vld("post", lat);
    check("post_latency", lat, 3);
    check("post_sum", {7'd0, total_sum}, 32'hF);
    accept();
    check("post_cnt", {24'd0, pair_cnt}, exp_pairs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
